// File: rtl/interrupt_ctrl_pkg.sv
// interrupt_pkg
// Shared definitions for the interrupt sequencer: the sequencer state type,
// default cause-vector geometry, named cause indices and default constants
// for the repeat mask and handler entry address.
// No ports (package).

package interrupt_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    localparam int NCAUSE_DEF = 23;
    localparam int NNMI_DEF   = 6;

    // Cause indices; a lower index means a higher priority.
    localparam int C_RESET = 0;
    localparam int C_ILL   = 1;
    localparam int C_MAL   = 2;
    localparam int C_PFF   = 3;
    localparam int C_PFLS  = 4;
    localparam int C_TRAP  = 5;
    localparam int C_OVF   = 6;
    localparam int C_EXT0  = 7;
    localparam int C_EXT1  = 8;
    localparam int C_EXT2  = 9;
    localparam int C_EXT3  = 10;
    localparam int C_EXT4  = 11;
    localparam int C_EXT5  = 12;
    localparam int C_EXT6  = 13;
    localparam int C_EXT7  = 14;
    localparam int C_EXT8  = 15;
    localparam int C_EXT9  = 16;
    localparam int C_EXT10 = 17;
    localparam int C_EXT11 = 18;
    localparam int C_EXT12 = 19;
    localparam int C_EXT13 = 20;
    localparam int C_EXT14 = 21;
    localparam int C_EXT15 = 22;

    // Causes whose handler re-executes the faulting instruction.
    localparam logic [NCAUSE_DEF-1:0] REPEAT_MASK_DEF = 23'h00_003C;
    localparam logic [31:0]           ISR_VEC_DEF     = 32'h0000_0100;

endpackage

// File: rtl/interrupt_ctrl_cause_prio_enc.sv
// cause_prio_enc
// Lowest-set-bit priority encoder (bit 0 wins).
// Ports:
//   req    in   W   request vector
//   grant  out  W   one-hot grant of the lowest set request bit (0 if none)
//   idx    out  5   index of the granted bit (0 if none)
//   valid  out  1   at least one request bit set

module cause_prio_enc
    import interrupt_pkg::*;
#(
    parameter int W = NCAUSE_DEF
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] grant,
    output logic [4:0]   idx,
    output logic         valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = 5'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl
// Interrupt sequencer: latches raw cause pulses into a sticky pending
// register, masks them with the SPR status mask, and sequences handler
// entry (jisr + PC redirect to ISR_VEC) at instruction boundaries and the
// return redirect to the saved PC on eret.
//
// Build option: INTERRUPT_CTRL_NEST_EN
//   defined   - in the handler, a cause of higher priority than the one being
//               serviced re-enters the handler (nested entry).
//   undefined - in the handler only the reset cause (bit 0) can re-enter;
//               everything else waits until after the return.
//
// Ports:
//   clk         in   1       system clock
//   reset       in   1       synchronous active-high reset
//   ev          in   NCAUSE  raw cause pulses (bit 0 highest priority)
//   sr_mask     in   NCAUSE  cause enable mask from the SPR file
//   instr_done  in   1       instruction retire strobe (interrupt boundary)
//   eret        in   1       eret retire strobe
//   epc         in   32      saved return PC from the SPR file
//   jisr        out  1       interrupt-entry strobe
//   mca         out  NCAUSE  masked cause snapshot taken at entry
//   rpt         out  1       repeat flag of the highest-priority taken cause
//   pc_load     out  1       PC redirect strobe
//   pc_target   out  32      PC redirect address
//   in_handler  out  1       handler active
//
// State table:
//   state      | meaning
//   ST_RUN     | normal execution, waiting for a boundary with a cause
//   ST_ENTRY   | jisr and pc_load to ISR_VEC asserted this cycle
//   ST_HANDLER | handler executing, waiting for eret (or nested entry)
//   ST_RETURN  | pc_load to the saved epc asserted this cycle

module interrupt_ctrl
    import interrupt_pkg::*;
#(
    parameter int                NCAUSE      = NCAUSE_DEF,
    parameter int                NNMI        = NNMI_DEF,
    parameter logic [NCAUSE-1:0] REPEAT_MASK = NCAUSE'(REPEAT_MASK_DEF),
    parameter logic [31:0]       ISR_VEC     = ISR_VEC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCAUSE-1:0] ev,
    input  logic [NCAUSE-1:0] sr_mask,
    input  logic              instr_done,
    input  logic              eret,
    input  logic [31:0]       epc,
    output logic              jisr,
    output logic [NCAUSE-1:0] mca,
    output logic              rpt,
    output logic              pc_load,
    output logic [31:0]       pc_target,
    output logic              in_handler
);

    localparam logic [NCAUSE-1:0] NMI_BITS = NCAUSE'((64'd1 << NNMI) - 64'd1);

    state_t            state;
    logic [NCAUSE-1:0] pend;
    logic [NCAUSE-1:0] eff;
    logic [NCAUSE-1:0] take;
    logic [NCAUSE-1:0] clr;
    logic [NCAUSE-1:0] nest_mask;
    logic              nest_hit;
    logic              enter;
    logic              rpt_next;

    logic [NCAUSE-1:0] eff_grant;
    logic [4:0]        eff_idx;
    logic              eff_valid;

    // Non-maskable causes are forced enabled regardless of sr_mask.
    assign eff = pend & (sr_mask | NMI_BITS);

    cause_prio_enc #(.W(NCAUSE)) u_eff_enc (
        .req   (eff),
        .grant (eff_grant),
        .idx   (eff_idx),
        .valid (eff_valid)
    );

`ifdef INTERRUPT_CTRL_NEST_EN
    logic [NCAUSE-1:0] mca_grant;
    logic [4:0]        mca_idx;
    logic              mca_valid;

    cause_prio_enc #(.W(NCAUSE)) u_mca_enc (
        .req   (mca),
        .grant (mca_grant),
        .idx   (mca_idx),
        .valid (mca_valid)
    );

    // Every bit strictly below the cause currently being serviced.
    assign nest_mask = mca_grant - NCAUSE'(1);
    assign nest_hit  = eff_valid && mca_valid && (eff_idx < mca_idx);
`else
    assign nest_mask = NCAUSE'(1) << C_RESET;
    assign nest_hit  = eff_valid && (eff_idx == 5'(C_RESET));
`endif

    // A nested entry only takes the higher-priority bits; lower-priority
    // causes stay pending for after the return.
    always_comb begin
        take  = (state == ST_RUN) ? eff : (eff & nest_mask);
        enter = instr_done &&
                (((state == ST_RUN) && eff_valid) ||
                 ((state == ST_HANDLER) && !eret && nest_hit));
        clr   = enter ? take : '0;
    end

    // The lowest set bit of take is always the lowest set bit of eff
    // (nest_mask is a contiguous low-order mask), so eff's encoder serves.
    assign rpt_next = |(eff_grant & REPEAT_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            pend       <= '0;
            mca        <= '0;
            rpt        <= 1'b0;
            jisr       <= 1'b0;
            pc_load    <= 1'b0;
            pc_target  <= '0;
            in_handler <= 1'b0;
        end else begin
            // Set wins over clear for a bit re-raised in the taking cycle.
            pend    <= (pend & ~clr) | ev;
            jisr    <= 1'b0;
            pc_load <= 1'b0;

            if (enter) begin
                state      <= ST_ENTRY;
                mca        <= take;
                rpt        <= rpt_next;
                jisr       <= 1'b1;
                pc_load    <= 1'b1;
                pc_target  <= ISR_VEC;
                in_handler <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        state <= ST_RUN;
                    end
                    ST_ENTRY: begin
                        state <= ST_HANDLER;
                    end
                    ST_HANDLER: begin
                        if (eret) begin
                            state     <= ST_RETURN;
                            pc_load   <= 1'b1;
                            pc_target <= epc;
                        end
                    end
                    ST_RETURN: begin
                        state      <= ST_RUN;
                        in_handler <= 1'b0;
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

    localparam logic [22:0] ALL  = 23'h7F_FFFF;
    localparam logic [22:0] NONE = 23'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] ev;
    logic [22:0] sr_mask;
    logic        instr_done;
    logic        eret;
    logic [31:0] epc;
    logic        jisr;
    logic [22:0] mca;
    logic        rpt;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model (transaction level: strobes, handler flag, pending set)
    logic [22:0] rep_mask = 23'h00_003C;
    logic [22:0] m_pend, m_mca;
    logic        m_rpt, m_jisr, m_pcl, m_inh, m_ret;
    logic [31:0] m_pct;

    interrupt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ev         (ev),
        .sr_mask    (sr_mask),
        .instr_done (instr_done),
        .eret       (eret),
        .epc        (epc),
        .jisr       (jisr),
        .mca        (mca),
        .rpt        (rpt),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [22:0] v);
        for (int i = 0; i < 23; i++) if (v[i]) return i;
        return 23;
    endfunction

    function automatic logic [22:0] nest_allowed(input logic [22:0] cur);
`ifdef INTERRUPT_CTRL_NEST_EN
        logic [22:0] one = 23'h1;
        return (one << lowest(cur)) - one;
`else
        return 23'h1;
`endif
    endfunction

    task automatic model_step(input logic r, input logic [22:0] e, input logic [22:0] m,
                              input logic i, input logic x, input logic [31:0] p);
        logic [22:0] eff, tk;
        logic        nret, was_ret;
        if (r) begin
            m_pend = '0; m_mca = '0; m_rpt = 0; m_jisr = 0; m_pcl = 0;
            m_inh = 0; m_ret = 0; m_pct = '0;
            return;
        end
        eff  = m_pend & (m | 23'h3F);
        tk   = '0;
        nret = 0;
        if (!(m_jisr || m_ret)) begin
            if (!m_inh) begin
                if (i) tk = eff;
            end else if (x) begin
                nret = 1;
            end else if (i) begin
                tk = eff & nest_allowed(m_mca);
            end
        end
        was_ret = m_ret;
        m_pend  = (m_pend & ~tk) | e;
        m_jisr  = (tk != 0);
        m_ret   = nret;
        m_pcl   = m_jisr || nret;
        if (tk != 0) begin
            m_mca = tk;
            m_rpt = rep_mask[lowest(tk)];
            m_pct = 32'h100;
            m_inh = 1;
        end
        if (nret) m_pct = p;
        if (was_ret) m_inh = 0;
    endtask

    task automatic tick(input logic r, input logic [22:0] e, input logic [22:0] m,
                        input logic i, input logic x, input logic [31:0] p);
        reset = r; ev = e; sr_mask = m; instr_done = i; eret = x; epc = p;
        @(posedge clk);
        model_step(r, e, m, i, x, p);
        #1;
        check("jisr", 32'(jisr), 32'(m_jisr));
        check("pc_load", 32'(pc_load), 32'(m_pcl));
        check("in_handler", 32'(in_handler), 32'(m_inh));
        check("mca", 32'(mca), 32'(m_mca));
        check("rpt", 32'(rpt), 32'(m_rpt));
        if (m_pcl) check("pc_target", pc_target, m_pct);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, NONE, ALL, 0, 0, 32'h0);
    endtask

    task automatic do_return(input logic [31:0] p);
        tick(0, NONE, ALL, 0, 1, p);
        idle(1);
    endtask

    initial begin
        logic [22:0] msk, e;
        logic        bz, i, x, r;

        // Reset
        tick(1, NONE, NONE, 0, 0, 0);
        tick(1, NONE, NONE, 0, 0, 0);
        check("rst_jisr", 32'(jisr), 32'h0);
        check("rst_pc_target", pc_target, 32'h0);
        check("rst_in_handler", 32'(in_handler), 32'h0);

        // Single enabled external cause
        tick(0, 23'h80, ALL, 0, 0, 0);
        idle(3);
        tick(0, NONE, ALL, 1, 0, 0);
        check("tp1_jisr", 32'(jisr), 32'h1);
        check("tp1_mca", 32'(mca), 32'h80);
        check("tp1_rpt", 32'(rpt), 32'h0);
        check("tp1_pc_load", 32'(pc_load), 32'h1);
        check("tp1_pc_target", pc_target, 32'h100);
        idle(1);
        check("tp1_jisr_pulse", 32'(jisr), 32'h0);
        tick(0, NONE, ALL, 0, 1, 32'h0000_2004);
        check("ret_pc_load", 32'(pc_load), 32'h1);
        check("ret_pc_target", pc_target, 32'h2004);
        check("ret_in_handler", 32'(in_handler), 32'h1);
        idle(1);
        check("ret_in_handler_fall", 32'(in_handler), 32'h0);
        tick(0, NONE, ALL, 1, 0, 0);
        check("pend7_cleared", 32'(jisr), 32'h0);

        // Two causes, repeat flag from the higher-priority one
        tick(0, 23'h88, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
        check("tp2_mca", 32'(mca), 32'h88);
        check("tp2_rpt", 32'(rpt), 32'h1);
        idle(1);
        do_return(32'h3000);

        // Masked cause, then an NMI
        tick(0, 23'h80, NONE, 0, 0, 0);
        tick(0, NONE, NONE, 1, 0, 0);
        check("tp3_masked", 32'(jisr), 32'h0);
        tick(0, 23'h02, NONE, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
        check("tp3_jisr", 32'(jisr), 32'h1);
        check("tp3_mca", 32'(mca), 32'h82);
        idle(1);
        do_return(32'h3100);

        // Higher-priority cause while in the handler
        tick(0, 23'h80, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
        idle(1);
        tick(0, 23'h04, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
`ifdef INTERRUPT_CTRL_NEST_EN
        check("nest_jisr", 32'(jisr), 32'h1);
        check("nest_mca", 32'(mca), 32'h04);
        check("nest_rpt", 32'(rpt), 32'h1);
        idle(1);
        do_return(32'h3200);
`else
        check("nonest_jisr", 32'(jisr), 32'h0);
        do_return(32'h3200);
        tick(0, NONE, ALL, 1, 0, 0);
        check("nonest_late_jisr", 32'(jisr), 32'h1);
        check("nonest_late_mca", 32'(mca), 32'h04);
        idle(1);
        do_return(32'h3300);
`endif

        // Reset during ENTRY
        tick(0, 23'h80, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
        tick(1, NONE, ALL, 0, 0, 0);
        check("rst_entry_jisr", 32'(jisr), 32'h0);
        check("rst_entry_pc_load", 32'(pc_load), 32'h0);
        check("rst_entry_mca", 32'(mca), 32'h0);
        check("rst_entry_in_handler", 32'(in_handler), 32'h0);
        tick(0, NONE, ALL, 1, 0, 0);
        check("rst_entry_pend", 32'(jisr), 32'h0);

        // eret and instr_done together with a pending cause: eret wins
        tick(0, 23'h80, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 0, 0);
        idle(1);
        tick(0, 23'h100, ALL, 0, 0, 0);
        tick(0, NONE, ALL, 1, 1, 32'h4000);
        check("eret_wins_jisr", 32'(jisr), 32'h0);
        check("eret_wins_pc_target", pc_target, 32'h4000);
        idle(1);
        tick(0, NONE, ALL, 1, 0, 0);
        check("after_ret_mca", 32'(mca), 32'h100);
        idle(1);
        do_return(32'h4100);

        // Same-cycle event is not in the snapshot
        tick(0, 23'h80, ALL, 0, 0, 0);
        tick(0, 23'h200, ALL, 1, 0, 0);
        check("same_cycle_mca", 32'(mca), 32'h80);
        idle(1);
        do_return(32'h4200);
        tick(0, NONE, ALL, 1, 0, 0);
        check("same_cycle_later_mca", 32'(mca), 32'h200);
        idle(1);
        do_return(32'h4300);

        // Randomized traffic against the model
        msk = ALL;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) msk = 23'($urandom);
            bz = m_jisr || m_ret;
            e  = ($urandom_range(0, 3) == 0) ? (23'h1 << $urandom_range(0, 22)) : NONE;
            i  = !bz && ($urandom_range(0, 2) == 0);
            x  = !bz && ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 599) == 0);
            tick(r, e, msk, i, x, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt sequencer that produces the `jisr`, `mca` and `rpt` strobes consumed by the special-purpose register file, and drives the PC redirect on interrupt entry and on `eret`. Raw cause events are latched into a sticky pending register and masked by the status mask read from the SPR file. The highest-priority cause is selected, and entry into the handler is sequenced at an instruction boundary. On `eret`, the saved PC returned by the SPR file is reloaded.

## Interface
- `NCAUSE`, 23: number of cause lines; equals the `mca` width.
- `NNMI`, 6: causes `[NNMI-1:0]` are non-maskable.
- `REPEAT_MASK`, 23'h00_003C: causes whose handler re-executes the faulting instruction (`rpt=1`).
- `ISR_VEC`, 32'h0000_0100: handler entry address.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ev`  in  NCAUSE  raw cause pulses; bit 0 has the highest priority.
- `sr_mask`  in  NCAUSE  enable mask from the SPR file; 1 = cause enabled.
- `instr_done`  in  1  one-cycle strobe when an instruction retires (interrupt boundary).
- `eret`  in  1  one-cycle strobe when an `eret` instruction retires.
- `epc`  in  32  saved return PC from the SPR file.
- `jisr`  out  1  one-cycle interrupt-entry strobe to the SPR file.
- `mca`  out  NCAUSE  masked cause snapshot; valid when `jisr=1`.
- `rpt`  out  1  repeat flag; valid when `jisr=1`.
- `pc_load`  out  1  one-cycle PC redirect strobe.
- `pc_target`  out  32  redirect address; valid when `pc_load=1`.
- `in_handler`  out  1  high from the entry cycle until the `eret` redirect cycle.

## Operation
- Pending update each cycle: `pend <= (pend & ~clr) | ev`.
- `clr` holds the bits taken this cycle. A new event on the same bit in the same cycle survives (set wins over clear).
- Effective mask: `eff = pend & ({sr_mask[NCAUSE-1:NNMI], {NNMI{1'b1}}})`.
- State machine RUN / ENTRY / HANDLER / RETURN:
  - RUN: `instr_done` with `eff != 0` → ENTRY. Register `mca <= eff` and `clr <= eff`.
  - ENTRY: assert `jisr` and `pc_load`, with `pc_target=ISR_VEC` → HANDLER.
  - HANDLER: `eret` → RETURN, with `epc` captured this cycle.
  - HANDLER, nesting: `instr_done` with an eligible cause → ENTRY (see Configuration).
  - RETURN: assert `pc_load`, with `pc_target` = captured `epc` → RUN.
- `rpt` is the REPEAT_MASK bit of the lowest-index set bit of `mca`. It is computed by the priority encoder when entering ENTRY and registered.
- `eret` and `instr_done` with pending causes in the same HANDLER cycle: `eret` wins. Causes stay pending and are taken at the first `instr_done` in RUN.
- `instr_done` or `eret` asserted in ENTRY or RETURN is ignored. The protocol guarantees neither occurs there.
- `eret` in RUN is ignored (no redirect).

## Timing
- Reset: state=RUN; `pend`, `mca`, `rpt`, `jisr`, `pc_load`, `pc_target`, `in_handler` all 0.
- Reset mid-ENTRY or mid-RETURN aborts the sequence. No strobe is issued in the following cycle.
- Entry latency: `jisr` and `pc_load` assert exactly 1 cycle after the qualifying `instr_done`.
- Return latency: `pc_load` asserts exactly 1 cycle after `eret`.
- `jisr` and `pc_load` are single-cycle pulses.
- `mca` and `rpt` hold their value until the next ENTRY.
- An event arriving in the same cycle as the qualifying `instr_done` is not in the current `mca`. It stays pending.
- `in_handler` rises with `jisr` and falls in the cycle after the RETURN `pc_load`.

## Configuration
- `INTERRUPT_CTRL_NEST_EN` defined:
  - In HANDLER, an `instr_done` with `eff & prio_above(mca)` nonzero re-enters ENTRY (nested entry).
  - `prio_above(mca)` means all bits with an index lower than the lowest set bit of `mca`.
  - The SPR file saves state again on the nested `jisr`.
- Undefined:
  - In HANDLER, only cause bit 0 (reset) can trigger ENTRY.
  - All other causes remain pending until after the return.

## Structure
- `interrupt_pkg` holds:
  - the state enum;
  - `NCAUSE_DEF` and `NNMI_DEF`;
  - named cause indices (`C_RESET=0`, `C_ILL=1`, `C_MAL=2`, `C_PFF=3`, `C_PFLS=4`, `C_TRAP=5`, `C_OVF=6`, `C_EXT0=7`, …);
  - the default `REPEAT_MASK` and `ISR_VEC` constants.
- One sub-module, `cause_prio_enc`:
  - parameterised lowest-set-bit encoder;
  - outputs a one-hot grant, a 5-bit index and a valid flag;
  - reused for `rpt` selection and for the nesting compare.

## Test plan
- Reset, then `ev[7]=1` for 1 cycle with `sr_mask[7]=1`, then `instr_done` at cycle 5 → at cycle 6: `jisr=1`, `mca=23'h80`, `rpt=0`, `pc_load=1`, `pc_target=32'h100`; `pend[7]` cleared.
- `ev[3]` and `ev[7]` pending with all bits enabled, then `instr_done` → `mca=23'h88`, `rpt=1` (bit 3 is in REPEAT_MASK).
- `ev[7]` pending with `sr_mask=0`, then `instr_done` → no `jisr`. Then raise `ev[1]` and `instr_done` → `jisr` with `mca=23'h82`.
- In HANDLER, `eret` with `epc=32'h0000_2004` → next cycle `pc_load=1`, `pc_target=32'h2004`; `in_handler` falls the cycle after.
- In HANDLER, `ev[2]` then `instr_done`:
  - with `INTERRUPT_CTRL_NEST_EN` and current `mca=23'h80` → nested `jisr`;
  - without it → no `jisr` until after the return, then `jisr` at the next `instr_done`.
- `reset` asserted in the ENTRY cycle → next cycle all outputs 0, `pend=0`.
